execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage_if.sv | 24 ++
 rtl/execute_stage.sv | 158 +++++++++++++++
 tb/tb_execute_stage.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Handshake and result bus of the execute stage: decoded instruction in,
// result/store beat out, and the branch redirect toward the PC.
interface execute_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        mem_we;
  logic [10:0] mem_wadrs;
  logic        branch_valid;
  logic [10:0] branch_address;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, result, mem_we, mem_wadrs, branch_valid, branch_address
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, result, mem_we, mem_wadrs, branch_valid, branch_address
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: 16x32 register file, ALU, store and branch redirect behind a one-beat output register.
// Optional macro PSR_FLAGS_EN adds Z/N/C flags and conditional branches.
module execute_stage (
  input  logic           clk,
  input  logic           reset,
  execute_stage_if.slave bus
);
  typedef enum logic [2:0] {
    OP_NOOP   = 3'b000,
    OP_OR     = 3'b001,
    OP_AND    = 3'b010,
    OP_SUB    = 3'b011,
    OP_ADD    = 3'b100,
    OP_BRANCH = 3'b101,
    OP_STORE  = 3'b110,
    OP_LOAD   = 3'b111
  } opcode_e;

  logic [31:0] regfile_r [16];
  logic        out_valid_r, mem_we_r, branch_valid_r, squash_r;
  logic [31:0] result_r;
  logic [10:0] mem_wadrs_r, branch_address_r;

  opcode_e     opcode_s;
  logic [10:0] src_field_s, dest_field_s;
  logic [31:0] op_a_s, op_src_s;
  logic [32:0] alu_s;
  logic        is_alu_s, has_beat_s, is_branch_s, cond_true_s;
  logic        in_ready_s, accept_s, live_s, mem_dest_s, beat_fire_s, reg_we_s, take_s;
  logic        unused_s;

  // Bit 32 carries ADD carry-out or SUBTRACT no-borrow; LOAD/STORE pass the source through.
  function automatic logic [32:0] alu_f(input opcode_e op, input logic [31:0] a, input logic [31:0] s);
    logic [32:0] res;
    res = 33'd0;
    case (op)
      OP_ADD:  res = {1'b0, a} + {1'b0, s};
      OP_SUB:  begin
        res     = {1'b0, a} - {1'b0, s};
        res[32] = ~res[32];
      end
      OP_AND:  res = {1'b0, a & s};
      OP_OR:   res = {1'b0, a | s};
      default: res = {1'b0, s};
    endcase
    return res;
  endfunction

  assign opcode_s     = opcode_e'(bus.instr[31:29]);
  assign src_field_s  = bus.instr[21:11];
  assign dest_field_s = bus.instr[10:0];
  assign op_a_s       = regfile_r[dest_field_s[3:0]];
  assign op_src_s     = bus.instr[23] ? {21'd0, src_field_s} : regfile_r[src_field_s[3:0]];
  assign alu_s        = alu_f(opcode_s, op_a_s, op_src_s);

  assign in_ready_s   = !out_valid_r || bus.out_ready;
  assign accept_s     = bus.in_valid && in_ready_s;
  assign live_s       = accept_s && !squash_r;
  assign mem_dest_s   = (opcode_s == OP_STORE) || bus.instr[22];
  assign beat_fire_s  = live_s && has_beat_s;
  assign reg_we_s     = beat_fire_s && !mem_dest_s;
  assign take_s       = live_s && is_branch_s && cond_true_s;

  // Opcode class decode
  always_comb begin
    is_alu_s    = 1'b0;
    has_beat_s  = 1'b0;
    is_branch_s = 1'b0;
    case (opcode_s)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        is_alu_s   = 1'b1;
        has_beat_s = 1'b1;
      end
      OP_LOAD, OP_STORE: has_beat_s  = 1'b1;
      OP_BRANCH:         is_branch_s = 1'b1;
      default:           has_beat_s  = 1'b0;
    endcase
  end

`ifdef PSR_FLAGS_EN
  logic flag_z_r, flag_n_r, flag_c_r;

  // Flags track every live ALU op; squashed ops leave them untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_z_r <= 1'b0;
      flag_n_r <= 1'b0;
      flag_c_r <= 1'b0;
    end else if (live_s && is_alu_s) begin
      flag_z_r <= (alu_s[31:0] == 32'd0);
      flag_n_r <= alu_s[31];
      flag_c_r <= alu_s[32];
    end
  end

  // Branch condition select from src[21:19]
  always_comb begin
    cond_true_s = 1'b0;
    case (src_field_s[10:8])
      3'b000:  cond_true_s = 1'b1;
      3'b001:  cond_true_s = flag_z_r;
      3'b010:  cond_true_s = !flag_z_r;
      3'b011:  cond_true_s = flag_c_r;
      3'b100:  cond_true_s = flag_n_r;
      default: cond_true_s = 1'b0;
    endcase
  end

  assign unused_s = ^bus.instr[28:24];
`else
  assign cond_true_s = (src_field_s[10:8] == 3'b000);
  assign unused_s    = ^{bus.instr[28:24], alu_s[32]};
`endif

  // Register file is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (reg_we_s) begin
      regfile_r[dest_field_s[3:0]] <= alu_s[31:0];
    end
  end

  // Output beat, branch pulse and squash flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r      <= 1'b0;
      mem_we_r         <= 1'b0;
      result_r         <= 32'd0;
      mem_wadrs_r      <= 11'd0;
      branch_valid_r   <= 1'b0;
      branch_address_r <= 11'd0;
      squash_r         <= 1'b0;
    end else begin
      branch_valid_r <= take_s;
      if (take_s) begin
        branch_address_r <= dest_field_s;
      end
      if (accept_s) begin
        squash_r <= take_s;
      end
      if (in_ready_s) begin
        out_valid_r <= beat_fire_s;
        mem_we_r    <= beat_fire_s && mem_dest_s;
        if (beat_fire_s) begin
          result_r    <= alu_s[31:0];
          mem_wadrs_r <= dest_field_s;
        end
      end
    end
  end

  assign bus.in_ready       = in_ready_s;
  assign bus.out_valid      = out_valid_r;
  assign bus.result         = result_r;
  assign bus.mem_we         = mem_we_r;
  assign bus.mem_wadrs      = mem_wadrs_r;
  assign bus.branch_valid   = branch_valid_r;
  assign bus.branch_address = branch_address_r;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized traffic
// against an instruction-level reference model (register array, flags, squash bit).
module tb_execute_stage;
  logic clk;
  logic reset;
  execute_stage_if bus();

  execute_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int          checks;
  int          errors;
  logic [31:0] rf [16];
  logic        m_valid, m_we, m_bv, m_squash, m_accept;
  logic [31:0] m_result;
  logic [10:0] m_wadrs, m_ba;
`ifdef PSR_FLAGS_EN
  logic        m_z, m_n, m_c;
`endif
  logic        obs_in_ready, exp_in_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [2:0] op, input logic st, input logic dt,
                                     input logic [10:0] src, input logic [10:0] dst);
    return {op, 5'd0, st, dt, src, dst};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_we = 1'b0; m_bv = 1'b0; m_squash = 1'b0;
    m_result = 32'd0; m_wadrs = 11'd0; m_ba = 11'd0;
`ifdef PSR_FLAGS_EN
    m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
`endif
  endtask

  // Instruction-level effect of one clock edge with the given inputs.
  task automatic model_step(input logic v, input logic [31:0] ins, input logic rdy);
    logic [2:0]  op;
    logic [10:0] sf, df;
    logic [31:0] a, s, r;
    logic        beat, alu, tk;
    m_accept = v && (!m_valid || rdy);
    m_bv = 1'b0;
    if (!m_valid || rdy) m_valid = 1'b0;
    if (m_accept && m_squash) begin
      m_squash = 1'b0;
    end else if (m_accept) begin
      op = ins[31:29]; sf = ins[21:11]; df = ins[10:0];
      s = ins[23] ? 32'(sf) : rf[sf[3:0]];
      a = rf[df[3:0]];
      r = s; beat = 1'b1; alu = 1'b1; tk = 1'b0;
      case (op)
        3'b100: r = a + s;
        3'b011: r = a - s;
        3'b010: r = a & s;
        3'b001: r = a | s;
        3'b111, 3'b110: alu = 1'b0;
        default: begin beat = 1'b0; alu = 1'b0; end
      endcase
      if (op == 3'b101) begin
`ifdef PSR_FLAGS_EN
        case (sf[10:8])
          3'b000: tk = 1'b1;
          3'b001: tk = m_z;
          3'b010: tk = !m_z;
          3'b011: tk = m_c;
          3'b100: tk = m_n;
          default: tk = 1'b0;
        endcase
`else
        tk = (sf[10:8] == 3'b000);
`endif
        if (tk) begin m_bv = 1'b1; m_ba = df; m_squash = 1'b1; end
      end
      if (beat) begin
        m_valid = 1'b1; m_result = r; m_wadrs = df;
        m_we = (op == 3'b110) || ins[22];
        if (!m_we) rf[df[3:0]] = r;
      end
`ifdef PSR_FLAGS_EN
      if (alu) begin
        m_z = (r == 32'd0);
        m_n = r[31];
        m_c = (op == 3'b100) ? ({1'b0, a} + {1'b0, s} > 33'h0_FFFF_FFFF) :
              (op == 3'b011) ? (a >= s) : 1'b0;
      end
`endif
    end
  endtask

  // Drive at the falling edge, sample in_ready, advance model, step one clock.
  task automatic drive_cycle(input logic v, input logic [31:0] ins, input logic rdy);
    bus.in_valid = v; bus.instr = ins; bus.out_ready = rdy;
    #1;
    obs_in_ready = bus.in_ready;
    exp_in_ready = !m_valid || rdy;
    model_step(v, ins, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.instr = 32'd0; bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks += 6;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
    if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    if (bus.mem_wadrs !== 11'd0) begin errors++; $display("FAIL reset_wadrs: got %h expected 0", bus.mem_wadrs); end
    if (bus.branch_valid !== 1'b0) begin errors++; $display("FAIL reset_bv: got %b expected 0", bus.branch_valid); end
    if (bus.branch_address !== 11'd0) begin errors++; $display("FAIL reset_ba: got %h expected 0", bus.branch_address); end
    reset = 1'b1;
  endtask

  task automatic test_load_add();
    drive_cycle(1'b1, mk(3'b111, 1'b1, 1'b0, 11'd5, 11'd1), 1'b1);
    checks += 2;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL load_valid: got %b expected 1", bus.out_valid); end
    if (bus.result !== 32'd5) begin errors++; $display("FAIL load_result: got %h expected 5", bus.result); end
    drive_cycle(1'b1, mk(3'b100, 1'b1, 1'b0, 11'd3, 11'd1), 1'b1);
    checks += 3;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", bus.out_valid); end
    if (bus.result !== 32'd8) begin errors++; $display("FAIL add_result: got %h expected 8", bus.result); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL add_mem_we: got %b expected 0", bus.mem_we); end
    drive_cycle(1'b1, mk(3'b100, 1'b1, 1'b1, 11'd0, 11'd1), 1'b1);
    checks += 3;
    if (bus.result !== 32'd8) begin errors++; $display("FAIL r1_readback: got %h expected 8", bus.result); end
    if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rb_mem_we: got %b expected 1", bus.mem_we); end
    if (bus.mem_wadrs !== 11'd1) begin errors++; $display("FAIL rb_wadrs: got %h expected 001", bus.mem_wadrs); end
  endtask

  task automatic test_store_stall();
    drive_cycle(1'b0, 32'd0, 1'b1);
    drive_cycle(1'b1, mk(3'b110, 1'b1, 1'b0, 11'h7FF, 11'h010), 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 32'd0, 1'b0);
      checks += 5;
      if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", obs_in_ready); end
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", bus.out_valid); end
      if (bus.result !== 32'h7FF) begin errors++; $display("FAIL stall_result: got %h expected 7ff", bus.result); end
      if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL stall_mem_we: got %b expected 1", bus.mem_we); end
      if (bus.mem_wadrs !== 11'h010) begin errors++; $display("FAIL stall_wadrs: got %h expected 010", bus.mem_wadrs); end
    end
    drive_cycle(1'b0, 32'd0, 1'b1);
    checks += 2;
    if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", obs_in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_beat: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_branch_squash();
    drive_cycle(1'b1, mk(3'b111, 1'b1, 1'b0, 11'h055, 11'd5), 1'b1);
    drive_cycle(1'b1, mk(3'b101, 1'b0, 1'b0, 11'h000, 11'h123), 1'b1);
    checks += 3;
    if (bus.branch_valid !== 1'b1) begin errors++; $display("FAIL br_valid: got %b expected 1", bus.branch_valid); end
    if (bus.branch_address !== 11'h123) begin errors++; $display("FAIL br_addr: got %h expected 123", bus.branch_address); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL br_no_beat: got %b expected 0", bus.out_valid); end
    drive_cycle(1'b1, mk(3'b100, 1'b1, 1'b0, 11'd7, 11'd5), 1'b1);
    checks += 2;
    if (bus.branch_valid !== 1'b0) begin errors++; $display("FAIL br_pulse_len: got %b expected 0", bus.branch_valid); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL squash_beat: got %b expected 0", bus.out_valid); end
    drive_cycle(1'b1, mk(3'b100, 1'b1, 1'b1, 11'd0, 11'd5), 1'b1);
    checks += 1;
    if (bus.result !== 32'h55) begin errors++; $display("FAIL squash_regwrite: got %h expected 55", bus.result); end
  endtask

  task automatic test_subtract_flags();
    logic exp_n_taken;
`ifdef PSR_FLAGS_EN
    exp_n_taken = 1'b1;
`else
    exp_n_taken = 1'b0;
`endif
    drive_cycle(1'b1, mk(3'b111, 1'b1, 1'b0, 11'd0, 11'd2), 1'b1);
    drive_cycle(1'b1, mk(3'b011, 1'b1, 1'b0, 11'd1, 11'd2), 1'b1);
    checks += 1;
    if (bus.result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_result: got %h expected ffffffff", bus.result); end
    drive_cycle(1'b1, mk(3'b101, 1'b0, 1'b0, {3'b100, 8'd0}, 11'h0AA), 1'b1);
    checks += 1;
    if (bus.branch_valid !== exp_n_taken) begin errors++; $display("FAIL br_on_n: got %b expected %b", bus.branch_valid, exp_n_taken); end
    drive_cycle(1'b1, 32'd0, 1'b1);
    drive_cycle(1'b1, mk(3'b101, 1'b0, 1'b0, {3'b011, 8'd0}, 11'h0BB), 1'b1);
    checks += 1;
    if (bus.branch_valid !== 1'b0) begin errors++; $display("FAIL br_on_c: got %b expected 0", bus.branch_valid); end
  endtask

  task automatic test_reset_mid_stall();
    drive_cycle(1'b0, 32'd0, 1'b1);
    drive_cycle(1'b1, mk(3'b110, 1'b1, 1'b0, 11'h3C3, 11'h020), 1'b0);
    drive_cycle(1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    #1;
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_drop_valid: got %b expected 0", bus.out_valid); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL async_drop_we: got %b expected 0", bus.mem_we); end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_cycle(1'b1, mk(3'b100, 1'b1, 1'b1, 11'd0, 11'd1), 1'b1);
    checks += 2;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL first_accept: got %b expected 1", bus.out_valid); end
    if (bus.result !== 32'd8) begin errors++; $display("FAIL rf_retained: got %h expected 8", bus.result); end
  endtask

  task automatic test_random();
    logic [31:0] cur;
    logic        v, rdy, hold;
    logic        st;
    hold = 1'b0; cur = 32'd0;
    for (int i = 0; i < 416; i++) begin
      if (i < 16) begin
        v = 1'b1; rdy = 1'b1;
        cur = mk(3'b111, 1'b1, 1'b0, 11'($urandom), {7'd0, 4'(i)});
      end else begin
        v   = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 9) < 7);
        if (!hold) begin
          st  = 1'($urandom);
          cur = {3'($urandom_range(0, 7)), 5'($urandom), st, 1'($urandom),
                 st ? 11'($urandom) : {7'($urandom), 4'($urandom_range(0, 3))},
                 {7'($urandom), 4'($urandom_range(0, 3))}};
        end
      end
      drive_cycle(v, cur, rdy);
      hold = v && !m_accept;
      checks += 3;
      if (obs_in_ready !== exp_in_ready) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, obs_in_ready, exp_in_ready); end
      if (bus.out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, bus.out_valid, m_valid); end
      if (bus.branch_valid !== m_bv) begin errors++; $display("FAIL rnd_bv[%0d]: got %b expected %b", i, bus.branch_valid, m_bv); end
      if (m_bv) begin
        checks++;
        if (bus.branch_address !== m_ba) begin errors++; $display("FAIL rnd_ba[%0d]: got %h expected %h", i, bus.branch_address, m_ba); end
      end
      if (m_valid) begin
        checks += 2;
        if (bus.result !== m_result) begin errors++; $display("FAIL rnd_result[%0d]: got %h expected %h", i, bus.result, m_result); end
        if (bus.mem_we !== m_we) begin errors++; $display("FAIL rnd_mem_we[%0d]: got %b expected %b", i, bus.mem_we, m_we); end
        if (m_we) begin
          checks++;
          if (bus.mem_wadrs !== m_wadrs) begin errors++; $display("FAIL rnd_wadrs[%0d]: got %h expected %h", i, bus.mem_wadrs, m_wadrs); end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_add();
    test_store_stall();
    test_branch_squash();
    test_subtract_flags();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
